multiphase_clk_gen: RTL
=======================

Name: multiphase_clk_gen

Overview:
- Synthesizable, parametrised N-channel non-free-running phase generator for the switched-capacitor front end (phi_l1/phi_l2/phi_r-style channels plus one-shot phi_p pulse).
- Derives all phases from the master clock start_clk with a programmable period, per-channel rise/fall positions and graceful stop.
- Sits between the control register block and the SC switch drivers.

Parameters:
- NCH, 4, number of phase channels.
- CW, 16, width of period counter and all position/width fields.

Ports:
- start_clk  in  1  master clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run request, level-sensitive.
- period  in  CW  cycles per phase period; values 0 and 1 treated as 2.
- rise_pos  in  NCH*CW  packed per-channel rise position; channel i uses bits [i*CW +: CW].
- fall_pos  in  NCH*CW  packed per-channel fall position, same packing.
- pulse_w  in  CW  phi_p width in cycles; 0 means no pulse.
- burst_len  in  CW  periods per burst; 0 means continuous (used only with MPCG_BURST_EN).
- phi  out  NCH  phase outputs, registered.
- phi_p  out  1  one-shot start pulse, registered.
- running  out  1  high in RUN or DRAIN.
- period_tick  out  1  one-cycle pulse on the last count of each period.
- done  out  1  one-cycle burst-complete pulse.

Behaviour:
- Reset: state=IDLE, cnt=0, shadows=0, phi=0, phi_p=0, running=0, period_tick=0, done=0.
- States:
  - IDLE: enable=1 -> RUN. cnt<=0. Load shadow copies of period, rise_pos, fall_pos and pulse_w.
  - RUN: cnt increments and wraps at eff_period-1 to 0. At each wrap, reload the shadows, so config changes take effect only on a period boundary. enable=0 -> DRAIN.
  - DRAIN: counting continues. At cnt==eff_period-1 -> IDLE. enable=1 seen in DRAIN -> back to RUN with no gap in the count.
- eff_period = max(shadow period, 2).
- Channel i window, from shadows r and f:
  - r<f: high when r<=cnt<f.
  - r>f: high when cnt>=r or cnt<f (wrap-around window).
  - r==f: constant low.
  - Any position >= eff_period never matches. Behaviour then follows the rules above with that edge absent, e.g. f>=eff_period and r<eff_period gives high from r to the end of the period.
- Latency: phi reflects cnt one cycle later (registered). The first high on a channel with r=0 appears 1 cycle after entering RUN. No combinational path from inputs to outputs.
- phi forced 0 whenever the state register is IDLE. After DRAIN -> IDLE, all phi are 0 on the next cycle; a period is never truncated.
- phi_p: high for pulse_w cycles starting at the first RUN cycle after IDLE. Issued once per IDLE -> RUN entry, not on DRAIN -> RUN. If the count exceeds the period, the pulse simply continues until its width is reached.
- period_tick: registered, high one cycle per period, aligned with phi for cnt==eff_period-1.
- enable toggling high then low within one cycle of RUN entry still completes one full period.

Optional Feature:
- Macro MPCG_BURST_EN.
- Defined:
  - A period counter counts wraps in RUN/DRAIN.
  - When shadow burst_len!=0 and the count reaches burst_len, the block enters IDLE at that period end regardless of enable, and pulses done for 1 cycle.
  - A restart requires enable to go low and then high again.
  - burst_len is latched at IDLE -> RUN.
- Undefined: burst_len ignored, done tied 0, continuous operation.

Decomposition:
- Package mpcg_pkg: state enum (IDLE, RUN, DRAIN) and the default CW constant.
- Sub-module mpcg_phase_win: per-channel window comparator plus output flop, inputs cnt/r/f/eff_period/active. Instantiated NCH times via generate.

Test Plan:
- Config period=8, ch0 r=0 f=4, ch1 r=4 f=0, ch2 r=0 f=2, ch3 r=2 r=2 (f=2); enable=1 -> ch0/ch1 complementary 4/4 and ch2 2/8 duty; ch3 stays 0. First ch0 high 1 cycle after RUN entry; period_tick every 8 cycles.
- Change period to 12 mid-period (cnt=3) -> current period stays 8 cycles; the next period is 12.
- enable=1 with pulse_w=3 -> phi_p high exactly 3 cycles from RUN entry. Drop enable at cnt=2 -> outputs run to cnt=7, then all 0 and running=0. Re-enable during DRAIN -> no gap, no second phi_p.
- period=1, ch0 r=0 f=1 -> eff_period=2, ch0 alternates high/low. Separately, r=9 f=3 with period=8 -> high cnt 0..2 only.
- Assert rst at cnt=5 in RUN -> next cycle all outputs 0 and state IDLE. enable held high -> RUN re-entered and phi_p re-issued.
- MPCG_BURST_EN defined, burst_len=3, period=4 -> exactly 12 counted cycles, done pulses once, block idles with enable still 1. Toggling enable low then high restarts.

Source files
------------

// File: rtl/mpcg_pkg.sv
// rtl/mpcg_pkg.sv - shared state encoding and defaults for the multiphase clock generator
package mpcg_pkg;

    // Default width of the period counter and every position/width field
    localparam int MPCG_CW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mpcg_state_t;

endpackage

// File: rtl/mpcg_phase_win.sv
// rtl/mpcg_phase_win.sv - one phase channel: rise/fall window compare and output flop
module mpcg_phase_win
    import mpcg_pkg::*;
#(
    parameter int CW = MPCG_CW
) (
    input  logic          start_clk,
    input  logic          rst,
    input  logic          active,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] f,
    input  logic [CW-1:0] eff_period,
    output logic          phi
);

    logic [CW-1:0] r_eff;
    logic [CW-1:0] f_eff;
    logic          hit;

    // Positions past the period end are pulled to eff_period so that edge never fires
    always_comb begin
        r_eff = (r >= eff_period) ? eff_period : r;
        f_eff = (f >= eff_period) ? eff_period : f;
        hit   = 1'b0;
        if (r_eff < f_eff) begin
            hit = (cnt >= r_eff) && (cnt < f_eff);
        end else if (r_eff > f_eff) begin
            hit = (cnt >= r_eff) || (cnt < f_eff);
        end
    end

    // Registered phase output, held low while the generator is idle
    always_ff @(posedge start_clk) begin
        if (rst) begin
            phi <= 1'b0;
        end else begin
            phi <= active && hit;
        end
    end

endmodule

// File: rtl/multiphase_clk_gen.sv
// rtl/multiphase_clk_gen.sv - N-channel SC phase generator; MPCG_BURST_EN enables burst mode
module multiphase_clk_gen
    import mpcg_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = MPCG_CW
) (
    input  logic              start_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CW-1:0]     period,
    input  logic [NCH*CW-1:0] rise_pos,
    input  logic [NCH*CW-1:0] fall_pos,
    input  logic [CW-1:0]     pulse_w,
    input  logic [CW-1:0]     burst_len,
    output logic [NCH-1:0]    phi,
    output logic              phi_p,
    output logic              running,
    output logic              period_tick,
    output logic              done
);

    mpcg_state_t       state_q;
    mpcg_state_t       state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     period_sh;
    logic [CW-1:0]     pulse_w_sh;
    logic [CW-1:0]     pcnt_q;
    logic [NCH*CW-1:0] rise_sh;
    logic [NCH*CW-1:0] fall_sh;
    logic [CW-1:0]     eff_period;
    logic              active;
    logic              last_cnt;
    logic              wrap;
    logic              start;
    logic              burst_end;
    logic              blocked;
    logic              phi_p_q;
    logic              tick_q;

    assign eff_period = (period_sh < CW'(2)) ? CW'(2) : period_sh;
    assign active     = (state_q != IDLE);
    assign last_cnt   = (cnt_q == eff_period - CW'(1));
    assign wrap       = active && last_cnt;
    assign start      = (state_q == IDLE) && enable && !blocked;

`ifdef MPCG_BURST_EN
    logic [CW-1:0] burst_sh;
    logic [CW-1:0] bcnt_q;
    logic          blocked_q;
    logic          done_q;

    assign burst_end = wrap && (burst_sh != '0) && (bcnt_q == burst_sh - CW'(1));
    assign blocked   = blocked_q;
    assign done      = done_q;

    // Completed-period counter, done pulse, and restart lockout until enable drops
    always_ff @(posedge start_clk) begin
        if (rst) begin
            burst_sh  <= '0;
            bcnt_q    <= '0;
            blocked_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= burst_end;
            if (burst_end) begin
                blocked_q <= 1'b1;
            end else if (!enable) begin
                blocked_q <= 1'b0;
            end
            if (start) begin
                burst_sh <= burst_len;
                bcnt_q   <= '0;
            end else if (wrap) begin
                bcnt_q <= bcnt_q + CW'(1);
            end
        end
    end
`else
    logic unused_burst_len;

    assign unused_burst_len = ^burst_len;
    assign burst_end        = 1'b0;
    assign blocked          = 1'b0;
    assign done             = 1'b0;
`endif

    // State register
    always_ff @(posedge start_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: periods always finish; a burst end overrides enable
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (burst_end) begin
                    state_d = IDLE;
                end else if (!enable) begin
                    state_d = last_cnt ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (burst_end) begin
                    state_d = IDLE;
                end else if (enable) begin
                    state_d = RUN;
                end else if (last_cnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Period counter and shadow config, refreshed only at entry and at period boundaries
    always_ff @(posedge start_clk) begin
        if (rst) begin
            cnt_q      <= '0;
            period_sh  <= '0;
            rise_sh    <= '0;
            fall_sh    <= '0;
            pulse_w_sh <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
            if (start) begin
                period_sh  <= period;
                rise_sh    <= rise_pos;
                fall_sh    <= fall_pos;
                pulse_w_sh <= pulse_w;
            end
        end else if (last_cnt) begin
            cnt_q     <= '0;
            period_sh <= period;
            rise_sh   <= rise_pos;
            fall_sh   <= fall_pos;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // One-shot start pulse: fires only on entry from IDLE, runs its full width
    always_ff @(posedge start_clk) begin
        if (rst) begin
            phi_p_q <= 1'b0;
            pcnt_q  <= '0;
        end else if (start) begin
            phi_p_q <= (pulse_w != '0);
            pcnt_q  <= CW'(1);
        end else if (state_q == IDLE) begin
            phi_p_q <= 1'b0;
        end else if (phi_p_q) begin
            if (pcnt_q >= pulse_w_sh) begin
                phi_p_q <= 1'b0;
            end else begin
                pcnt_q <= pcnt_q + CW'(1);
            end
        end
    end

    // Period tick, registered to line up with phi for the last count
    always_ff @(posedge start_clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mpcg_phase_win #(
            .CW(CW)
        ) u_win (
            .start_clk (start_clk),
            .rst       (rst),
            .active    (active),
            .cnt       (cnt_q),
            .r         (rise_sh[i*CW +: CW]),
            .f         (fall_sh[i*CW +: CW]),
            .eff_period(eff_period),
            .phi       (phi[i])
        );
    end

    assign phi_p       = phi_p_q;
    assign running     = active;
    assign period_tick = tick_q;

endmodule
